// File: rtl/ge_grad_tracker_if.sv
// ge_grad_tracker_if: day-verdict handshake and progress/status bundle for ge_grad_tracker.
interface ge_grad_tracker_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             clear;
    logic             in_valid;
    logic             pass3;
    logic             in_ready;
    logic [2:0]       state;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_streak;
    logic             graduated;
    logic             expelled;
    logic             done;
    logic [7:0]       hist;

    modport master (
        output start, clear, in_valid, pass3,
        input  in_ready, state, pass_cnt, fail_streak, graduated, expelled, done, hist
    );

    modport slave (
        input  start, clear, in_valid, pass3,
        output in_ready, state, pass_cnt, fail_streak, graduated, expelled, done, hist
    );
endinterface

// File: rtl/ge_grad_tracker.sv
// ge_grad_tracker: probation FSM deciding GRADUATED/EXPELLED from daily pass3 verdicts.
// Optional 8-day verdict history is built when GE_TRACK_HISTORY_EN is defined.
module ge_grad_tracker #(
    parameter int PASS_NEED  = 8,
    parameter int FAIL_LIMIT = 3,
    parameter int PROB_EXIT  = 2,
    parameter int CNT_W      = 4
) (
    input logic             clk,
    input logic             rst,
    ge_grad_tracker_if.slave bus
);
    typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, PROB = 3'd2, GRAD = 3'd3, EXPEL = 3'd4} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pass_q, pass_d, streak_q, streak_d;
    logic [CNT_W-1:0] pass_inc, streak_inc;
    logic             done_q, done_d;
    logic             hs, enroll;

    assign hs         = bus.in_valid && bus.in_ready;
    assign enroll     = state_q == IDLE && bus.start;
    assign pass_inc   = pass_q + 1'b1;
    assign streak_inc = streak_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        streak_d = streak_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d  = RUN;
                pass_d   = '0;
                streak_d = '0;
            end
            RUN: if (hs) begin
                if (bus.pass3) begin
                    pass_d   = pass_inc;
                    streak_d = '0;
                    state_d  = pass_inc == CNT_W'(PASS_NEED) ? GRAD : RUN;
                end else begin
                    state_d  = streak_inc == CNT_W'(FAIL_LIMIT) ? PROB : RUN;
                    streak_d = streak_inc == CNT_W'(FAIL_LIMIT) ? '0 : streak_inc;
                end
            end
            PROB: if (hs) begin
                if (bus.pass3) begin
                    pass_d   = pass_inc;
                    streak_d = streak_inc;
                    // graduation outranks the return to RUN
                    if (pass_inc == CNT_W'(PASS_NEED)) state_d = GRAD;
                    else if (streak_inc == CNT_W'(PROB_EXIT)) begin
                        state_d  = RUN;
                        streak_d = '0;
                    end
                end else state_d = EXPEL;
            end
            GRAD, EXPEL: if (bus.clear) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        done_d = (state_d == GRAD || state_d == EXPEL) && !(state_q == GRAD || state_q == EXPEL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pass_q   <= '0;
            streak_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pass_q   <= pass_d;
            streak_q <= streak_d;
            done_q   <= done_d;
        end
    end

`ifdef GE_TRACK_HISTORY_EN
    logic [7:0] hist_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= '0;
        else if (enroll) hist_q <= '0;
        else if (hs) hist_q <= {hist_q[6:0], bus.pass3};
    end
    assign bus.hist = hist_q;
`else
    logic unused_enroll;
    assign unused_enroll = enroll;
    assign bus.hist      = 8'h00;
`endif

    assign bus.in_ready    = state_q == RUN || state_q == PROB;
    assign bus.state       = state_q;
    assign bus.pass_cnt    = pass_q;
    assign bus.fail_streak = streak_q;
    assign bus.graduated   = state_q == GRAD;
    assign bus.expelled    = state_q == EXPEL;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_ge_grad_tracker.sv
// tb_ge_grad_tracker: table vectors, hand-written corner sequences and random days vs a reference model.
module tb_ge_grad_tracker;
    localparam int PASS_NEED  = 8;
    localparam int FAIL_LIMIT = 3;
    localparam int PROB_EXIT  = 2;
    localparam int CNT_W      = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    ge_grad_tracker_if #(.CNT_W(CNT_W)) bus ();

    ge_grad_tracker #(
        .PASS_NEED(PASS_NEED), .FAIL_LIMIT(FAIL_LIMIT), .PROB_EXIT(PROB_EXIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic s, c, v, p;
        int   st, pc, fs, dn;
    } vec_t;

    // reference: a student record advanced one day at a time
    string m_phase;
    int    m_pass, m_run;
    int    m_done;
    int    m_hist[$];

    function automatic int phase_code(string ph);
        return ph == "idle" ? 0 : ph == "run" ? 1 : ph == "prob" ? 2 : ph == "grad" ? 3 : 4;
    endfunction

    function automatic void model_reset();
        m_phase = "idle"; m_pass = 0; m_run = 0; m_done = 0; m_hist = {};
    endfunction

    function automatic void model_day(logic s, logic c, logic v, logic p);
        bit was_final = (m_phase == "grad" || m_phase == "expel");
        bit took = v && (m_phase == "run" || m_phase == "prob");
        string ph = m_phase;
        if (ph == "idle" && s) begin
            m_phase = "run"; m_pass = 0; m_run = 0; m_hist = {};
        end else if (was_final && c) m_phase = "idle";
        else if (took && !p && ph == "prob") m_phase = "expel";
        else if (took && p) begin
            m_pass++;
            m_run = (ph == "run") ? 0 : m_run + 1;
            if (m_pass == PASS_NEED) m_phase = "grad";
            else if (ph == "prob" && m_run == PROB_EXIT) begin m_phase = "run"; m_run = 0; end
        end else if (took) begin
            m_run++;
            if (m_run == FAIL_LIMIT) begin m_phase = "prob"; m_run = 0; end
        end
        if (took) begin
            m_hist.push_front(int'(p));
            if (m_hist.size() > 8) void'(m_hist.pop_back());
        end
        m_done = int'((m_phase == "grad" || m_phase == "expel") && !was_final);
    endfunction

    function automatic int model_hist();
        int h = 0;
`ifdef GE_TRACK_HISTORY_EN
        foreach (m_hist[i]) h += m_hist[i] << i;
`endif
        return h;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_model();
        int ph = phase_code(m_phase);
        chk("state", int'(bus.state), ph);
        chk("in_ready", int'(bus.in_ready), int'(ph == 1 || ph == 2));
        chk("pass_cnt", int'(bus.pass_cnt), m_pass);
        chk("fail_streak", int'(bus.fail_streak), m_run);
        chk("graduated", int'(bus.graduated), int'(ph == 3));
        chk("expelled", int'(bus.expelled), int'(ph == 4));
        chk("done", int'(bus.done), m_done);
        chk("hist", int'(bus.hist), model_hist());
    endtask

    task automatic step(logic s, logic c, logic v, logic p);
        @(negedge clk);
        bus.start = s; bus.clear = c; bus.in_valid = v; bus.pass3 = p;
        model_day(s, c, v, p);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.start = 0; bus.clear = 0; bus.in_valid = 0; bus.pass3 = 0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_model();
    endtask

    vec_t tbl[$];

    task automatic add(logic s, logic c, logic v, logic p, int st, int pc, int fs, int dn);
        vec_t r;
        r.s = s; r.c = c; r.v = v; r.p = p; r.st = st; r.pc = pc; r.fs = fs; r.dn = dn;
        tbl.push_back(r);
    endtask

    initial begin
        bus.start = 0; bus.clear = 0; bus.in_valid = 0; bus.pass3 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_state", int'(bus.state), 0);
        chk("reset_pass", int'(bus.pass_cnt), 0);
        chk("reset_ready", int'(bus.in_ready), 0);

        // verdict while IDLE is dropped
        add(0,0,1,1, 0,0,0,0);
        add(1,0,0,0, 1,0,0,0);
        for (int i = 1; i < 8; i++) add(0,0,1,1, 1,i,0,0);
        add(0,0,1,1, 3,8,0,1);
        add(0,0,1,1, 3,8,0,0);
        add(1,0,0,0, 3,8,0,0);
        add(0,1,0,0, 0,8,0,0);
        add(1,0,0,0, 1,0,0,0);
        add(0,0,1,0, 1,0,1,0);
        add(0,0,1,0, 1,0,2,0);
        add(0,0,1,0, 2,0,0,0);
        add(0,0,1,0, 4,0,0,1);
        add(0,0,0,0, 4,0,0,0);
        add(0,1,0,0, 0,0,0,0);
        add(1,0,0,0, 1,0,0,0);
        add(0,0,1,0, 1,0,1,0);
        add(0,0,1,0, 1,0,2,0);
        add(0,0,1,0, 2,0,0,0);
        add(0,0,1,1, 2,1,1,0);
        add(0,0,1,1, 1,2,0,0);
        add(0,0,1,0, 1,2,1,0);
        add(0,0,1,0, 1,2,2,0);
        add(0,0,1,0, 2,2,0,0);
        add(0,0,0,1, 2,2,0,0);
        add(0,0,1,0, 4,2,0,1);
        add(0,1,0,0, 0,2,0,0);
        add(1,0,0,0, 1,0,0,0);
        add(0,0,1,0, 1,0,1,0);
        add(0,0,1,0, 1,0,2,0);
        add(0,0,1,1, 1,1,0,0);
        add(0,0,1,0, 1,1,1,0);
        add(0,0,1,0, 1,1,2,0);
        foreach (tbl[i]) begin
            @(negedge clk);
            bus.start = tbl[i].s; bus.clear = tbl[i].c; bus.in_valid = tbl[i].v; bus.pass3 = tbl[i].p;
            model_day(tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].p);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_state", i), int'(bus.state), tbl[i].st);
            chk($sformatf("vec%0d_pass", i), int'(bus.pass_cnt), tbl[i].pc);
            chk($sformatf("vec%0d_streak", i), int'(bus.fail_streak), tbl[i].fs);
            chk($sformatf("vec%0d_done", i), int'(bus.done), tbl[i].dn);
        end

        // graduation in PROB outranks return to RUN: 6 passes, 3 fails, then 2 passes
        do_reset();
        step(1,0,0,0);
        repeat (6) step(0,0,1,1);
        repeat (3) step(0,0,1,0);
        step(0,0,1,1);
        step(0,0,1,1);
        chk("prob_grad_state", int'(bus.state), 3);
        chk("prob_grad_done", int'(bus.done), 1);
        // clear and start together in GRAD: clear wins
        step(1,1,0,0);
        chk("clear_start_state", int'(bus.state), 0);

        // history of P,F,P,P
        step(1,0,0,0);
        step(0,0,1,1); step(0,0,1,0); step(0,0,1,1); step(0,0,1,1);
`ifdef GE_TRACK_HISTORY_EN
        chk("hist_pfpp", int'(bus.hist), 8'b0000_1011);
`else
        chk("hist_tied", int'(bus.hist), 0);
`endif

        // asynchronous reset between edges
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", int'(bus.state), 0);
        chk("arst_pass", int'(bus.pass_cnt), 0);
        chk("arst_ready", int'(bus.in_ready), 0);
        chk("arst_hist", int'(bus.hist), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            logic s, c, v, p;
            s = $urandom_range(0, 3) == 0;
            c = $urandom_range(0, 7) == 0;
            v = $urandom_range(0, 3) != 0;
            p = $urandom_range(0, 9) < 6;
            step(s, c, v, p);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
